// File: rtl/video_fb_reader.sv
// Frame-buffer reader: streams H_DISPLAY x V_DISPLAY words from Avalon-MM memory
// into a first-word-fall-through pixel FIFO with start-of-frame / end-of-line flags.
module video_fb_reader #(
  parameter int AVS_DW     = 16,
  parameter int AVS_AW     = 25,
  parameter int H_DISPLAY  = 640,
  parameter int V_DISPLAY  = 480,
  parameter int BASE_ADDR  = 0,
  parameter int FIFO_DEPTH = 32
) (
  input  logic              sys_clk,
  input  logic              sys_rst,
  input  logic              enable,
  output logic [AVS_AW-1:0] avm_address,
  output logic              avm_read,
  input  logic              avm_waitrequest,
  input  logic [AVS_DW-1:0] avm_readdata,
  input  logic              avm_readdatavalid,
  output logic              dst_vld,
  input  logic              dst_rdy,
  output logic [AVS_DW-1:0] dst_data,
  output logic              dst_sof,
  output logic              dst_eol,
  output logic              busy,
  output logic              overflow
);

  localparam int FAW = $clog2(FIFO_DEPTH);
  localparam int CW  = FAW + 1;
  localparam int PIX = H_DISPLAY * V_DISPLAY;
  localparam int RW  = (PIX > 1) ? $clog2(PIX) : 1;
  localparam int XW  = (H_DISPLAY > 1) ? $clog2(H_DISPLAY) : 1;
  localparam int YW  = (V_DISPLAY > 1) ? $clog2(V_DISPLAY) : 1;
  localparam logic [AVS_AW-1:0] BASE     = AVS_AW'(BASE_ADDR);
  localparam logic [RW-1:0]     REQ_LAST = RW'(PIX - 1);
  localparam logic [XW-1:0]     X_LAST   = XW'(H_DISPLAY - 1);
  localparam logic [YW-1:0]     Y_LAST   = YW'(V_DISPLAY - 1);
  localparam logic [CW-1:0]     DEPTH_C  = CW'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t            state_r;
  state_t            state_next_s;
  logic              avm_read_r;
  logic [AVS_AW-1:0] avm_address_r;
  logic [RW-1:0]     req_cnt_r;
  logic [CW-1:0]     out_r;
  logic [CW-1:0]     fifo_cnt_r;
  logic [FAW-1:0]    wr_ptr_r;
  logic [FAW-1:0]    rd_ptr_r;
  logic [AVS_DW-1:0] mem_r [FIFO_DEPTH];
  logic [XW-1:0]     x_r;
  logic [YW-1:0]     y_r;
  logic              overflow_r;

  logic              busy_s;
  logic              dst_vld_s;
  logic              dst_sof_s;
  logic              dst_eol_s;
  logic              pop_s;
  logic              flush_s;
  logic              full_s;
  logic              data_in_s;
  logic              push_s;
  logic              ovf_set_s;
  logic              accept_s;
  logic              ret_s;
  logic [CW-1:0]     fifo_cnt_next_s;
  logic [CW-1:0]     out_next_s;
  logic [CW:0]       credit_s;
  logic              read_next_s;

  // State register
  always_ff @(posedge sys_clk) begin
    if (!sys_rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Next-state logic; DRAIN waits for a stalled request and every outstanding return
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      IDLE: begin
        if (enable) state_next_s = FETCH;
        else        state_next_s = IDLE;
      end
      FETCH: begin
        if (!enable) state_next_s = DRAIN;
        else         state_next_s = FETCH;
      end
      DRAIN: begin
        if (!avm_read_r && (out_r == CW'(0))) state_next_s = IDLE;
        else                                   state_next_s = DRAIN;
      end
      default: state_next_s = IDLE;
    endcase
  end

  // Output and datapath control decode
  always_comb begin
    busy_s    = (state_r != IDLE);
    dst_vld_s = (fifo_cnt_r != CW'(0));
    dst_sof_s = dst_vld_s & (x_r == XW'(0)) & (y_r == YW'(0));
    dst_eol_s = dst_vld_s & (x_r == X_LAST);
    pop_s     = dst_vld_s & dst_rdy;
    flush_s   = (state_r == DRAIN) | (state_next_s == DRAIN);
    full_s    = (fifo_cnt_r == DEPTH_C);
    data_in_s = avm_readdatavalid & (state_r == FETCH) & ~flush_s;
    push_s    = data_in_s & (~full_s | pop_s);
    ovf_set_s = data_in_s & full_s & ~pop_s;
    accept_s  = avm_read_r & ~avm_waitrequest;
    // Stray returns with nothing outstanding must not wrap the counter
    ret_s     = avm_readdatavalid & (state_r != IDLE) & (out_r != CW'(0));
    if (flush_s) begin
      fifo_cnt_next_s = CW'(0);
    end else begin
      fifo_cnt_next_s = fifo_cnt_r + CW'(push_s) - CW'(pop_s);
    end
    case ({accept_s, ret_s})
      2'b10:   out_next_s = out_r + CW'(1);
      2'b01:   out_next_s = out_r - CW'(1);
      default: out_next_s = out_r;
    endcase
    // A new request is issued only if its return is guaranteed a FIFO slot
    credit_s = {1'b0, fifo_cnt_next_s} + {1'b0, out_next_s};
    if (avm_read_r && avm_waitrequest) begin
      read_next_s = 1'b1;
    end else if ((state_next_s == FETCH) && (credit_s < {1'b0, DEPTH_C})) begin
      read_next_s = 1'b1;
    end else begin
      read_next_s = 1'b0;
    end
  end

  // Avalon request address, frame request count and outstanding count
  always_ff @(posedge sys_clk) begin
    if (!sys_rst) begin
      avm_read_r    <= 1'b0;
      avm_address_r <= BASE;
      req_cnt_r     <= RW'(0);
      out_r         <= CW'(0);
    end else begin
      avm_read_r <= read_next_s;
      out_r      <= out_next_s;
      if (state_r == IDLE) begin
        avm_address_r <= BASE;
        req_cnt_r     <= RW'(0);
      end else if (accept_s) begin
        if (req_cnt_r == REQ_LAST) begin
          avm_address_r <= BASE;
          req_cnt_r     <= RW'(0);
        end else begin
          avm_address_r <= avm_address_r + AVS_AW'(1);
          req_cnt_r     <= req_cnt_r + RW'(1);
        end
      end else begin
        avm_address_r <= avm_address_r;
        req_cnt_r     <= req_cnt_r;
      end
    end
  end

  // Pixel storage; contents are don't-care while the count is zero
  always_ff @(posedge sys_clk) begin
    if (push_s) begin
      mem_r[wr_ptr_r] <= avm_readdata;
    end
  end

  // FIFO pointers, raster position and sticky overflow
  always_ff @(posedge sys_clk) begin
    if (!sys_rst) begin
      fifo_cnt_r <= CW'(0);
      wr_ptr_r   <= FAW'(0);
      rd_ptr_r   <= FAW'(0);
      x_r        <= XW'(0);
      y_r        <= YW'(0);
      overflow_r <= 1'b0;
    end else begin
      fifo_cnt_r <= fifo_cnt_next_s;
      if (flush_s) begin
        wr_ptr_r <= FAW'(0);
        rd_ptr_r <= FAW'(0);
      end else begin
        wr_ptr_r <= wr_ptr_r + FAW'(push_s);
        rd_ptr_r <= rd_ptr_r + FAW'(pop_s);
      end
      if (state_r == DRAIN) begin
        x_r <= XW'(0);
        y_r <= YW'(0);
      end else if (pop_s) begin
        if (x_r == X_LAST) begin
          x_r <= XW'(0);
          y_r <= (y_r == Y_LAST) ? YW'(0) : y_r + YW'(1);
        end else begin
          x_r <= x_r + XW'(1);
        end
      end
      if (ovf_set_s) begin
        overflow_r <= 1'b1;
      end
    end
  end

  assign avm_address = avm_address_r;
  assign avm_read    = avm_read_r;
  assign dst_vld     = dst_vld_s;
  assign dst_data    = mem_r[rd_ptr_r];
  assign dst_sof     = dst_sof_s;
  assign dst_eol     = dst_eol_s;
  assign busy        = busy_s;
  assign overflow    = overflow_r;

endmodule

// File: tb/tb_video_fb_reader.sv
// Scoreboard bench for video_fb_reader: 4x2 frame at 0x100, 4-entry FIFO,
// behavioural Avalon slave with 2-cycle read latency and programmable stalls.
module tb_video_fb_reader;

  localparam int DW    = 16;
  localparam int AW    = 25;
  localparam int H     = 4;
  localparam int V     = 2;
  localparam int BASE  = 32'h100;
  localparam int DEPTH = 4;

  logic          sys_clk;
  logic          sys_rst;
  logic          enable;
  logic [AW-1:0] avm_address;
  logic          avm_read;
  logic          avm_waitrequest;
  logic [DW-1:0] avm_readdata;
  logic          avm_readdatavalid;
  logic          dst_vld;
  logic          dst_rdy;
  logic [DW-1:0] dst_data;
  logic          dst_sof;
  logic          dst_eol;
  logic          busy;
  logic          overflow;

  int checks = 0;
  int passed = 0;

  logic [AW-1:0] acc_q[$];
  logic [DW+1:0] exp_q[$];
  logic [DW+1:0] obs_q[$];
  int            acc_total = 0;
  int            ret_total = 0;
  logic [AW-1:0] stall_addr = '1;
  int            stall_left = 0;
  bit            inject_extra = 1'b0;
  bit            p0_v = 1'b0;
  bit            p1_v = 1'b0;
  logic [DW-1:0] p0_d = '0;
  logic [DW-1:0] p1_d = '0;

  video_fb_reader #(
    .AVS_DW(DW), .AVS_AW(AW), .H_DISPLAY(H), .V_DISPLAY(V),
    .BASE_ADDR(BASE), .FIFO_DEPTH(DEPTH)
  ) dut (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .enable(enable),
    .avm_address(avm_address), .avm_read(avm_read),
    .avm_waitrequest(avm_waitrequest), .avm_readdata(avm_readdata),
    .avm_readdatavalid(avm_readdatavalid),
    .dst_vld(dst_vld), .dst_rdy(dst_rdy), .dst_data(dst_data),
    .dst_sof(dst_sof), .dst_eol(dst_eol), .busy(busy), .overflow(overflow)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  function automatic logic [DW-1:0] pix(input logic [AW-1:0] a);
    return a[DW-1:0] ^ 16'hC3A0;
  endfunction

  // Expected {data, sof, eol} from the word's offset in the frame buffer
  function automatic logic [DW+1:0] expect_item(input logic [AW-1:0] a);
    logic [AW-1:0] off;
    off = a - AW'(BASE);
    return {pix(a), off == AW'(0), (off % AW'(H)) == AW'(H - 1)};
  endfunction

  // Avalon slave: stalls on stall_addr, returns data two cycles after accept
  initial begin
    avm_waitrequest   = 1'b0;
    avm_readdatavalid = 1'b0;
    avm_readdata      = '0;
    forever begin
      @(negedge sys_clk);
      #2;
      avm_readdatavalid = p1_v;
      avm_readdata      = p1_d;
      if (p1_v) ret_total++;
      p1_v = p0_v;
      p1_d = p0_d;
      p0_v = 1'b0;
      if (inject_extra && !avm_readdatavalid) begin
        avm_readdatavalid = 1'b1;
        avm_readdata      = 16'hDEAD;
        inject_extra      = 1'b0;
      end
      if (avm_read && avm_address == stall_addr && stall_left > 0) begin
        avm_waitrequest = 1'b1;
        stall_left--;
      end else begin
        avm_waitrequest = 1'b0;
      end
      if (avm_read && !avm_waitrequest) begin
        p0_v = 1'b1;
        p0_d = pix(avm_address);
        acc_q.push_back(avm_address);
        exp_q.push_back(expect_item(avm_address));
        acc_total++;
      end
    end
  end

  // Sink monitor: records every pixel handed over
  initial begin
    forever begin
      @(negedge sys_clk);
      #3;
      if (sys_rst && dst_vld && dst_rdy) obs_q.push_back({dst_data, dst_sof, dst_eol});
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, checks=%0d passed=%0d", checks, passed);
    $fatal(1, "watchdog");
  end

  task automatic drain(output bit ok);
    enable = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge sys_clk);
      if (!busy) begin
        ok = 1'b1;
        break;
      end
    end
    repeat (4) @(negedge sys_clk);
    acc_q.delete();
    exp_q.delete();
    obs_q.delete();
  endtask

  task automatic test_reset();
    sys_rst = 1'b0; enable = 1'b0; dst_rdy = 1'b1;
    repeat (3) @(negedge sys_clk);
    checks++; if (avm_read !== 1'b0) $display("FAIL reset_read: got %0b want 0", avm_read); else passed++;
    checks++; if (avm_address !== AW'(BASE)) $display("FAIL reset_addr: got %h want %h", avm_address, AW'(BASE)); else passed++;
    checks++; if ({dst_vld, dst_sof, dst_eol} !== 3'b000) $display("FAIL reset_dst: got %b want 000", {dst_vld, dst_sof, dst_eol}); else passed++;
    checks++; if ({busy, overflow} !== 2'b00) $display("FAIL reset_flags: got %b want 00", {busy, overflow}); else passed++;
    sys_rst = 1'b1;
    @(negedge sys_clk);
  endtask

  task automatic test_basic_frame();
    bit ok;
    enable = 1'b1; dst_rdy = 1'b1;
    for (int i = 0; i < 300 && (acc_q.size() < 9 || obs_q.size() < 8); i++) @(negedge sys_clk);
    checks++;
    if (acc_q.size() < 9 || obs_q.size() < 8) begin
      $display("FAIL basic_timeout: got acc=%0d pix=%0d want 9 and 8", acc_q.size(), obs_q.size());
    end else begin
      passed++;
      for (int i = 0; i < 9; i++) begin
        checks++; if (acc_q[i] !== AW'(BASE + (i % 8))) $display("FAIL basic_addr[%0d]: got %h want %h", i, acc_q[i], AW'(BASE + (i % 8))); else passed++;
      end
      for (int i = 0; i < 8; i++) begin
        checks++; if (obs_q[i] !== exp_q[i]) $display("FAIL basic_pix[%0d]: got %h want %h", i, obs_q[i], exp_q[i]); else passed++;
      end
    end
    drain(ok);
    checks++; if (!ok) $display("FAIL basic_drain: busy got 1 want 0"); else passed++;
  endtask

  task automatic test_backpressure();
    bit ok;
    int max_seen;
    max_seen = 0;
    dst_rdy = 1'b0; enable = 1'b1;
    repeat (40) begin
      @(negedge sys_clk);
      if (acc_q.size() > max_seen) max_seen = acc_q.size();
    end
    checks++; if (max_seen != DEPTH) $display("FAIL bp_accepts: got %0d want %0d", max_seen, DEPTH); else passed++;
    checks++; if (overflow !== 1'b0) $display("FAIL bp_overflow: got %0b want 0", overflow); else passed++;
    checks++; if ({dst_vld, dst_sof} !== 2'b11) $display("FAIL bp_head_flags: got %b want 11", {dst_vld, dst_sof}); else passed++;
    checks++; if (dst_data !== pix(AW'(BASE))) $display("FAIL bp_head_data: got %h want %h", dst_data, pix(AW'(BASE))); else passed++;
    dst_rdy = 1'b1;
    for (int i = 0; i < 300 && obs_q.size() < 12; i++) @(negedge sys_clk);
    checks++;
    if (obs_q.size() < 12) begin
      $display("FAIL bp_timeout: got %0d pixels want 12", obs_q.size());
    end else begin
      passed++;
      for (int i = 0; i < 12; i++) begin
        checks++; if (obs_q[i] !== exp_q[i]) $display("FAIL bp_pix[%0d]: got %h want %h", i, obs_q[i], exp_q[i]); else passed++;
      end
    end
    drain(ok);
    checks++; if (!ok) $display("FAIL bp_drain: busy got 1 want 0"); else passed++;
  endtask

  task automatic test_waitrequest();
    bit ok;
    stall_addr = AW'(BASE + 2); stall_left = 3;
    enable = 1'b1; dst_rdy = 1'b1;
    for (int i = 0; i < 300 && (acc_q.size() < 6 || obs_q.size() < 6); i++) @(negedge sys_clk);
    checks++; if (stall_left != 0) $display("FAIL wr_hold: got %0d stall cycles left want 0", stall_left); else passed++;
    checks++;
    if (acc_q.size() < 6 || obs_q.size() < 6) begin
      $display("FAIL wr_timeout: got acc=%0d pix=%0d want 6 and 6", acc_q.size(), obs_q.size());
    end else begin
      passed++;
      for (int i = 0; i < 6; i++) begin
        checks++; if (acc_q[i] !== AW'(BASE + i)) $display("FAIL wr_addr[%0d]: got %h want %h", i, acc_q[i], AW'(BASE + i)); else passed++;
        checks++; if (obs_q[i] !== exp_q[i]) $display("FAIL wr_pix[%0d]: got %h want %h", i, obs_q[i], exp_q[i]); else passed++;
      end
    end
    stall_addr = '1;
    drain(ok);
    checks++; if (!ok) $display("FAIL wr_drain: busy got 1 want 0"); else passed++;
  endtask

  task automatic test_disable_mid();
    bit ok;
    int n1;
    enable = 1'b1; dst_rdy = 1'b1;
    for (int i = 0; i < 300 && acc_q.size() < 5; i++) @(negedge sys_clk);
    enable = 1'b0;
    @(negedge sys_clk);
    n1 = acc_q.size();
    checks++; if (busy !== 1'b1) $display("FAIL dis_busy_hold: got %0b want 1", busy); else passed++;
    for (int i = 0; i < 100 && busy; i++) @(negedge sys_clk);
    checks++; if (busy !== 1'b0) $display("FAIL dis_busy_end: got %0b want 0", busy); else passed++;
    checks++; if (ret_total != acc_total) $display("FAIL dis_returns: got %0d returns want %0d", ret_total, acc_total); else passed++;
    checks++; if (acc_q.size() != n1 || n1 > 6) $display("FAIL dis_no_new_req: got %0d accepts want %0d (<=6)", acc_q.size(), n1); else passed++;
    checks++; if (dst_vld !== 1'b0) $display("FAIL dis_flush: dst_vld got %0b want 0", dst_vld); else passed++;
    for (int i = 0; i < n1; i++) begin
      checks++; if (acc_q[i] !== AW'(BASE + i)) $display("FAIL dis_addr[%0d]: got %h want %h", i, acc_q[i], AW'(BASE + i)); else passed++;
    end
    acc_q.delete(); exp_q.delete(); obs_q.delete();
    enable = 1'b1;
    for (int i = 0; i < 100 && obs_q.size() < 1; i++) @(negedge sys_clk);
    checks++;
    if (obs_q.size() < 1) begin
      $display("FAIL dis_restart_timeout: got 0 pixels want 1");
    end else begin
      passed++;
      checks++; if (acc_q[0] !== AW'(BASE)) $display("FAIL dis_restart_addr: got %h want %h", acc_q[0], AW'(BASE)); else passed++;
      checks++; if (obs_q[0] !== exp_q[0]) $display("FAIL dis_restart_pix: got %h want %h", obs_q[0], exp_q[0]); else passed++;
      checks++; if (obs_q[0][1] !== 1'b1) $display("FAIL dis_restart_sof: got %0b want 1", obs_q[0][1]); else passed++;
    end
    drain(ok);
    checks++; if (!ok) $display("FAIL dis_drain: busy got 1 want 0"); else passed++;
  endtask

  task automatic test_overflow();
    enable = 1'b1; dst_rdy = 1'b0;
    repeat (30) @(negedge sys_clk);
    checks++; if (acc_q.size() != DEPTH) $display("FAIL ovf_fill: got %0d accepts want %0d", acc_q.size(), DEPTH); else passed++;
    checks++; if (overflow !== 1'b0) $display("FAIL ovf_pre: got %0b want 0", overflow); else passed++;
    inject_extra = 1'b1;
    repeat (3) @(negedge sys_clk);
    checks++; if (overflow !== 1'b1) $display("FAIL ovf_set: got %0b want 1", overflow); else passed++;
    checks++; if (dst_data !== pix(AW'(BASE))) $display("FAIL ovf_head: got %h want %h", dst_data, pix(AW'(BASE))); else passed++;
    dst_rdy = 1'b1;
    repeat (6) @(negedge sys_clk);
    checks++; if (overflow !== 1'b1) $display("FAIL ovf_sticky: got %0b want 1", overflow); else passed++;
    enable = 1'b0; sys_rst = 1'b0;
    @(negedge sys_clk);
    sys_rst = 1'b1;
    checks++; if (overflow !== 1'b0) $display("FAIL ovf_reset: got %0b want 0", overflow); else passed++;
    repeat (6) @(negedge sys_clk);
    acc_q.delete(); exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_reset_mid_fetch();
    enable = 1'b1; dst_rdy = 1'b1;
    for (int i = 0; i < 100 && acc_q.size() < 3; i++) @(negedge sys_clk);
    checks++; if (busy !== 1'b1) $display("FAIL rst_pre_busy: got %0b want 1", busy); else passed++;
    enable = 1'b0; sys_rst = 1'b0;
    @(negedge sys_clk);
    sys_rst = 1'b1;
    checks++; if ({avm_read, dst_vld, busy} !== 3'b000) $display("FAIL rst_mid: got read/vld/busy=%b want 000", {avm_read, dst_vld, busy}); else passed++;
    checks++; if (avm_address !== AW'(BASE)) $display("FAIL rst_mid_addr: got %h want %h", avm_address, AW'(BASE)); else passed++;
    repeat (6) @(negedge sys_clk);
    checks++; if ({dst_vld, busy} !== 2'b00) $display("FAIL rst_stray_returns: got vld/busy=%b want 00", {dst_vld, busy}); else passed++;
  endtask

  initial begin
    sys_rst = 1'b0; enable = 1'b0; dst_rdy = 1'b0;
    test_reset();
    test_basic_frame();
    test_backpressure();
    test_waitrequest();
    test_disable_mid();
    test_overflow();
    test_reset_mid_fetch();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
